// File: rtl/isqrt_result_fifo_if.sv
// Handshake bundle between the isqrt pipeline/issuer, the result FIFO and its consumer.
// The slave modport is the FIFO side. The master modport is the environment driving it.
interface isqrt_result_fifo_if;
  logic        issue;
  logic        credit_ok;
  logic [31:0] data_in;
  logic        data_vld;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_ready;

  modport master (
    output issue, data_in, data_vld, m_ready,
    input  credit_ok, m_data, m_valid
  );

  modport slave (
    input  issue, data_in, data_vld, m_ready,
    output credit_ok, m_data, m_valid
  );
endinterface

// File: rtl/isqrt_result_fifo.sv
// Result FIFO for the inverse-square-root pipeline, with in-flight credit tracking.
// Define ISQRT_RESULT_CNT_EN to add the res_cnt pop counter port.
module isqrt_result_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic               clk,
  input  logic               rst,
  isqrt_result_fifo_if.slave bus,
  output logic [AW:0]        fill,
  output logic               overflow,
  output logic               underflow
`ifdef ISQRT_RESULT_CNT_EN
  ,
  output logic [15:0]        res_cnt
`endif
);

  localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [31:0]   mem_q [DEPTH];
  logic [31:0]   mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   fill_q, fill_d;
  logic [AW:0]   inflight_q, inflight_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;
  logic          push, pop, full;
  logic [AW+1:0] occupancy;

  assign full = (fill_q == DEPTH_C);
  assign pop  = bus.m_valid & bus.m_ready;
  assign push = bus.data_vld & (~full | pop);

  always_comb begin
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    fill_d      = fill_q;
    inflight_d  = inflight_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (push) begin
      mem_d[wr_ptr_q] = bus.data_in;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    if (push && !pop) begin
      fill_d = fill_q + CNT_ONE;
    end else if (pop && !push) begin
      fill_d = fill_q - CNT_ONE;
    end
    if (bus.data_vld && full && !pop) begin
      overflow_d = 1'b1;
    end

    // A return with nothing in flight is a protocol error: hold at zero and flag it.
    unique case ({bus.issue, bus.data_vld})
      2'b10: if (inflight_q != DEPTH_C) inflight_d = inflight_q + CNT_ONE;
      2'b01: begin
        if (inflight_q == '0) underflow_d = 1'b1;
        else                  inflight_d  = inflight_q - CNT_ONE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fill_q      <= '0;
      inflight_q  <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fill_q      <= fill_d;
      inflight_q  <= inflight_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign occupancy     = {1'b0, fill_q} + {1'b0, inflight_q};
  assign bus.credit_ok = (occupancy < {1'b0, DEPTH_C});
  assign bus.m_valid   = (fill_q != '0);
  assign bus.m_data    = mem_q[rd_ptr_q];
  assign fill          = fill_q;
  assign overflow      = overflow_q;
  assign underflow     = underflow_q;

`ifdef ISQRT_RESULT_CNT_EN
  logic [15:0] res_cnt_q, res_cnt_d;

  always_comb begin
    res_cnt_d = res_cnt_q;
    if (pop) res_cnt_d = res_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) res_cnt_q <= '0;
    else      res_cnt_q <= res_cnt_d;
  end

  assign res_cnt = res_cnt_q;
`endif

endmodule

// File: tb/tb_isqrt_result_fifo.sv
// Scoreboard bench for isqrt_result_fifo at DEPTH=4: stimulus pushes expected words, a monitor pops them.
module tb_isqrt_result_fifo;
  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] fill;
  logic       overflow, underflow;
`ifdef ISQRT_RESULT_CNT_EN
  logic [15:0] res_cnt;
`endif

  isqrt_result_fifo_if bus ();

  isqrt_result_fifo #(.DEPTH(4), .AW(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .fill      (fill),
    .overflow  (overflow),
    .underflow (underflow)
`ifdef ISQRT_RESULT_CNT_EN
    ,
    .res_cnt   (res_cnt)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int rcv   = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bus.m_ready = 1'b1;
    for (int c = 0; c < 40 && bus.m_valid; c++) step();
    bus.m_ready = 1'b0;
    chk("drain_empty", 32'(bus.m_valid), 32'h0);
  endtask

  // Every accepted handshake must match the oldest outstanding expected word.
  always @(negedge clk) begin
    if (rst && bus.m_valid && bus.m_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL mon_unexpected: got %h expected none", bus.m_data);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        rcv++;
        if (bus.m_data !== e) begin
          bad++;
          $display("FAIL mon_data: got %h expected %h", bus.m_data, e);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int issued;
    int rcv_start;
    logic pend;
    logic [31:0] pval;

    rst = 1'b0;
    bus.issue = 1'b0; bus.data_vld = 1'b0; bus.data_in = '0; bus.m_ready = 1'b0;
    step(); step();
    rst = 1'b1;
    step();

    // 1. reset state
    chk("rst_m_valid",   32'(bus.m_valid),   32'h0);
    chk("rst_fill",      32'(fill),          32'h0);
    chk("rst_credit",    32'(bus.credit_ok), 32'h1);
    chk("rst_overflow",  32'(overflow),      32'h0);
    chk("rst_underflow", 32'(underflow),     32'h0);
    chk("rst_m_data",    bus.m_data,         32'h0);

    // 2. single pass
    bus.issue = 1'b1; step(); bus.issue = 1'b0;
    chk("p_credit", 32'(bus.credit_ok), 32'h1);
    bus.data_vld = 1'b1; bus.data_in = 32'h3F000000; exp_q.push_back(32'h3F000000);
    step(); bus.data_vld = 1'b0;
    chk("p_m_valid", 32'(bus.m_valid), 32'h1);
    chk("p_m_data",  bus.m_data,       32'h3F000000);
    chk("p_fill",    32'(fill),        32'h1);
    bus.m_ready = 1'b1; step(); bus.m_ready = 1'b0;
    chk("p_fill0",   32'(fill),        32'h0);
    chk("p_m_valid0", 32'(bus.m_valid), 32'h0);

    // 3. credit limit
    bus.issue = 1'b1;
    step(); step(); step();
    chk("c_credit3", 32'(bus.credit_ok), 32'h1);
    step(); bus.issue = 1'b0;
    chk("c_credit4", 32'(bus.credit_ok), 32'h0);
    for (int i = 0; i < 4; i++) begin
      bus.data_vld = 1'b1; bus.data_in = 32'h10 + 32'(i); exp_q.push_back(32'h10 + 32'(i));
      step();
    end
    bus.data_vld = 1'b0;
    chk("c_fill4",      32'(fill),          32'h4);
    chk("c_credit_full", 32'(bus.credit_ok), 32'h0);
    bus.m_ready = 1'b1; step(); bus.m_ready = 1'b0;
    chk("c_fill3",      32'(fill),          32'h3);
    chk("c_credit_pop", 32'(bus.credit_ok), 32'h1);

    // 4. overflow: refill to 4, then a result with no room is dropped
    bus.issue = 1'b1; bus.data_vld = 1'b1; bus.data_in = 32'h14; exp_q.push_back(32'h14);
    step(); bus.data_vld = 1'b0;
    chk("o_fill4", 32'(fill), 32'h4);
    step(); bus.issue = 1'b0;
    chk("o_credit", 32'(bus.credit_ok), 32'h0);
    bus.data_vld = 1'b1; bus.data_in = 32'h12345678;
    step(); bus.data_vld = 1'b0;
    chk("o_overflow",  32'(overflow),  32'h1);
    chk("o_underflow", 32'(underflow), 32'h0);
    chk("o_fill_keep", 32'(fill),      32'h4);
    chk("o_head_hold", bus.m_data,     32'h11);
    bus.issue = 1'b1; step(); bus.issue = 1'b0;
    bus.data_vld = 1'b1; bus.data_in = 32'h15; bus.m_ready = 1'b1; exp_q.push_back(32'h15);
    step(); bus.data_vld = 1'b0; bus.m_ready = 1'b0;
    chk("o_fill_both", 32'(fill),  32'h4);
    chk("o_head_next", bus.m_data, 32'h12);
    drain();
    chk("o_credit_end", 32'(bus.credit_ok), 32'h1);

    // 5. wrap: ten results through a one-cycle pipeline, issuer honours credit_ok
    rcv_start = rcv;
    issued = 0; pend = 1'b0; pval = '0;
    for (int c = 0; c < 300 && (issued < 10 || pend); c++) begin
      bus.m_ready  = 1'($urandom_range(0, 1));
      bus.data_vld = pend;
      bus.data_in  = pval;
      if (pend) exp_q.push_back(pval);
      pend = 1'b0;
      if (issued < 10 && bus.credit_ok) begin
        bus.issue = 1'b1; issued++; pend = 1'b1; pval = 32'(issued);
      end else begin
        bus.issue = 1'b0;
      end
      step();
    end
    bus.issue = 1'b0; bus.data_vld = 1'b0;
    drain();
    chk("w_count",    32'(rcv - rcv_start), 32'd10);
    chk("w_left",     32'(exp_q.size()),    32'd0);
    chk("w_overflow", 32'(overflow),        32'h1);
`ifdef ISQRT_RESULT_CNT_EN
    // 7 pops happened before this phase, plus the 10 streamed results
    chk("w_res_cnt", 32'(res_cnt), 32'd17);
`endif

    // 6. async reset with three results stored
    for (int i = 0; i < 3; i++) begin
      bus.issue = 1'b1; bus.data_vld = 1'b1; bus.data_in = 32'hA1 + 32'(i);
      exp_q.push_back(32'hA1 + 32'(i));
      step();
    end
    bus.issue = 1'b0; bus.data_vld = 1'b0;
    chk("r_fill3", 32'(fill), 32'h3);
    #2 rst = 1'b0;
    #1;
    exp_q.delete();
    chk("r_m_valid",  32'(bus.m_valid),   32'h0);
    chk("r_fill",     32'(fill),          32'h0);
    chk("r_m_data",   bus.m_data,         32'h0);
    chk("r_overflow", 32'(overflow),      32'h0);
    chk("r_credit",   32'(bus.credit_ok), 32'h1);
    step(); rst = 1'b1; step();
    bus.data_vld = 1'b1; bus.data_in = 32'hDEADBEEF;
    step(); bus.data_vld = 1'b0;
    chk("r_underflow", 32'(underflow), 32'h1);
    chk("r_fill_stray", 32'(fill),     32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
